sound_sequencer: RTL



---
 rtl/sound_pkg.sv | 14 +
 rtl/sound_melody_rom.sv | 22 ++
 rtl/sound_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: shared types and melody indices for the sound sequencer.
package sound_pkg;
  typedef logic [3:0] tone_key_t;
  typedef struct packed {
    tone_key_t  key;
    logic [3:0] dur;
  } note_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;
  localparam int IDX_W = 4;
  localparam logic [1:0] MEL_HIT   = 2'd0;
  localparam logic [1:0] MEL_SCALE = 2'd1;
  localparam logic [1:0] MEL_LONG  = 2'd2;
  localparam logic [1:0] MEL_NONE  = 2'd3;
endpackage

// File: rtl/sound_melody_rom.sv
// sound_melody_rom: combinational melody table; dur=0 marks the end of a melody.
module sound_melody_rom
  import sound_pkg::*;
(
  input  logic [1:0]       mel_i,
  input  logic [IDX_W-1:0] idx_i,
  output note_t            note_o
);
  always_comb begin
    note_o = '0;
    case (mel_i)
      MEL_HIT: begin
        if (idx_i == 4'd0) note_o = '{key: 4'd0, dur: 4'd2};
        if (idx_i == 4'd1) note_o = '{key: 4'd4, dur: 4'd2};
        if (idx_i == 4'd2) note_o = '{key: 4'd7, dur: 4'd4};
      end
      MEL_SCALE: if (idx_i < 4'd8) note_o = '{key: idx_i, dur: 4'd1};
      MEL_LONG: if (idx_i == 4'd0) note_o = '{key: 4'd12, dur: 4'd15};
      default: note_o = '0;
    endcase
  end
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays ROM melodies as timed tone keys with silent gaps.
// Define SOUND_SEQ_RETRIGGER_EN to let start restart a melody while busy.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_CYCLES = 315000,
  parameter int GAP_TICKS   = 1,
  parameter int MELODY_LEN  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] melody_sel,
  input  logic       stop,
  output logic       sound_enable,
  output logic [3:0] tone_key,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam int TW = $clog2(GAP_TICKS + 16);
  seq_state_t       state_q;
  logic [1:0]       mel_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       dur_q;
  logic [CW-1:0]    cyc_q;
  logic [TW-1:0]    ticks_q;
  logic             sound_enable_q, busy_q, done_q;
  tone_key_t        tone_key_q;
  logic             launch, wrap, play_end, gap_end, advance, fin;
  logic [IDX_W:0]   next_idx_d;
  logic [1:0]       rom_mel_d;
  logic [IDX_W-1:0] rom_idx_d;
  note_t            rom_note;
`ifdef SOUND_SEQ_RETRIGGER_EN
  assign launch = start && !stop;
`else
  assign launch = start && !stop && state_q == IDLE;
`endif
  assign wrap       = cyc_q == CW'(TICK_CYCLES - 1);
  assign play_end   = state_q == PLAY && wrap && (ticks_q + TW'(1)) == TW'(dur_q);
  assign gap_end    = state_q == GAP && wrap && (ticks_q + TW'(1)) == TW'(GAP_TICKS);
  assign advance    = GAP_TICKS == 0 ? play_end : gap_end;
  assign next_idx_d = {1'b0, idx_q} + (IDX_W + 1)'(1);
  // A launch reads entry 0 of the requested melody; otherwise look ahead one entry.
  assign rom_mel_d  = launch ? melody_sel : mel_q;
  assign rom_idx_d  = launch ? '0 : next_idx_d[IDX_W-1:0];
  assign fin        = next_idx_d == (IDX_W + 1)'(MELODY_LEN) || rom_note.dur == 4'd0;
  sound_melody_rom u_rom (
    .mel_i  (rom_mel_d),
    .idx_i  (rom_idx_d),
    .note_o (rom_note)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mel_q          <= '0;
      idx_q          <= '0;
      dur_q          <= '0;
      cyc_q          <= '0;
      ticks_q        <= '0;
      sound_enable_q <= 1'b0;
      tone_key_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop && state_q != IDLE) begin
        state_q        <= IDLE;
        sound_enable_q <= 1'b0;
        busy_q         <= 1'b0;
      end else if (launch) begin
        mel_q   <= melody_sel;
        idx_q   <= '0;
        cyc_q   <= '0;
        ticks_q <= '0;
        dur_q   <= rom_note.dur;
        if (rom_note.dur != 4'd0) begin
          state_q        <= PLAY;
          sound_enable_q <= 1'b1;
          tone_key_q     <= rom_note.key;
          busy_q         <= 1'b1;
        end else begin
          state_q        <= IDLE;
          sound_enable_q <= 1'b0;
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
        end
      end else if (advance) begin
        idx_q   <= next_idx_d[IDX_W-1:0];
        cyc_q   <= '0;
        ticks_q <= '0;
        dur_q   <= rom_note.dur;
        if (fin) begin
          state_q        <= IDLE;
          sound_enable_q <= 1'b0;
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
        end else begin
          state_q        <= PLAY;
          sound_enable_q <= 1'b1;
          tone_key_q     <= rom_note.key;
        end
      end else if (play_end) begin
        state_q        <= GAP;
        sound_enable_q <= 1'b0;
        cyc_q          <= '0;
        ticks_q        <= '0;
      end else if (state_q != IDLE) begin
        cyc_q   <= wrap ? '0 : cyc_q + CW'(1);
        ticks_q <= wrap ? ticks_q + TW'(1) : ticks_q;
      end
    end
  end
  assign sound_enable = sound_enable_q;
  assign tone_key     = tone_key_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule
